load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle controller between the core's memory stage and the data memory port. It accepts one load or store request at a time and checks alignment. It issues a single word-aligned memory transaction with byte enables, waits for the memory handshake, then returns load data shifted and sign- or zero-extended per RV32I funct3. It replaces direct wiring of the data memory and owns all byte/half/word handling for the pipeline.

## Interface

Parameters:
- `CPU_WORD`, 32, datapath and memory word width (only 32 supported)
- `ADDR_WIDTH`, 32, byte address width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 of the load/store
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  CPU_WORD  store data, LSB-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  CPU_WORD  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned access or illegal funct3; valid with `resp_valid`
- `mem_req`  out  1  memory request, held until granted
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_WIDTH  word address, bits [1:0] = 0
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  CPU_WORD  lane-replicated store data
- `mem_gnt`  in  1  memory accepted request this cycle
- `mem_rvalid`  in  1  load data valid this cycle
- `mem_rdata`  in  CPU_WORD  raw memory word

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch we/funct3/addr/wdata.
  - Request is legal: go to ISSUE.
  - Request is misaligned or illegal: go to RESP with err=1 and no memory access.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- ISSUE: `mem_req`=1 with stable addr/we/be/wdata until `mem_gnt`.
  - Store + gnt: go to RESP.
  - Load + gnt: go to WAIT.
- WAIT: on `mem_rvalid`, capture `mem_rdata` and go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE.
- Byte enables:
  - SB: 4'b0001 << addr[1:0]
  - SH: 4'b0011 << addr[1:0]
  - SW: 4'b1111
  - Loads: 4'b1111
- Store data: SB replicates wdata[7:0] to all lanes; SH replicates wdata[15:0] to both halves; SW passes through.
- Load data: shift the memory word right by 8·addr[1:0], then extend.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- `mem_rvalid` outside WAIT is ignored.

## Timing

- All outputs are registered or decoded from the registered state; there is no combinational path from `req_*` to `mem_*`.
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
- Best-case load (gnt in ISSUE cycle, rvalid next cycle): accept at T0, `mem_req` at T1, rvalid at T2, `resp_valid` at T3.
- Best-case store: `resp_valid` at T2.
- Error: `resp_valid`+`resp_err` at T1.
- Each cycle `mem_gnt` stalls extends ISSUE by one cycle; each cycle `mem_rvalid` is late extends WAIT by one cycle. There is no timeout.
- Throughput is at most one request per 4 cycles (load) or 3 cycles (store); `req_ready` is low from T1 until return to IDLE.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values.
  - A late `mem_rvalid` arriving after reset is dropped.
  - The memory is responsible for discarding any granted-but-incomplete transaction.
- `resp_valid` never overlaps `req_ready`=1 in the same cycle.

## Structure

- Package `lsu_pkg`: funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the `lsu_state_t` enum.
- Sub-module `load_align_extend`: combinational; inputs are the raw word, addr[1:0] and funct3; output is the shifted and extended word. It is instantiated once, on the WAIT capture path.
- The top level holds the FSM, request latches, byte-enable/wdata generation and the alignment checker.

## Test plan

- LB addr 0x103, mem word 0x80AA_BBCC, gnt immediate, rvalid +1 -> `resp_valid` at T3, rdata 0xFFFF_FF80, err 0.
- LHU addr 0x102 and LH addr 0x102, word 0x9234_5678 -> LHU rdata 0x0000_9234; LH rdata 0xFFFF_9234.
- SB addr 0x201, wdata 0x1234_56AB, gnt delayed 3 cycles -> `mem_req` held 4 cycles with stable outputs, be 4'b0010, wdata 0xABAB_ABAB, mem_addr 0x200, `resp_valid` the cycle after gnt.
- LW addr 0x102 and SH addr 0x301 -> no `mem_req`, `resp_valid`+`resp_err` at T1, rdata 0. funct3 011 -> same response.
- Reset pulled low while in WAIT, then `mem_rvalid` arrives after release -> outputs at reset values, no `resp_valid`, `req_ready`=1.
- Back-to-back requests with `req_valid` held high -> second request accepted only on the cycle after the first `resp_valid`, with no lost or duplicated responses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - controller state encoding
//   - access_ok(): legality and alignment check for one request
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lsu_state_t;

  // True when funct3 is legal for the access direction and the byte offset is naturally aligned.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational load data alignment.
// Shifts the raw memory word right by the byte offset and sign- or zero-extends it according to
// the load funct3.
//   raw     in   raw memory word
//   offset  in   byte offset within the word (addr[1:0])
//   funct3  in   load funct3
//   result  out  aligned, extended load data (0 for non-load encodings)
module load_align_extend
  import lsu_pkg::*;
#(
  parameter int unsigned CPU_WORD = 32
) (
  input  logic [CPU_WORD-1:0] raw,
  input  logic [1:0]          offset,
  input  logic [2:0]          funct3,
  output logic [CPU_WORD-1:0] result
);

  logic [CPU_WORD-1:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{(CPU_WORD-8){shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{(CPU_WORD-16){shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {{(CPU_WORD-8){1'b0}}, shifted[7:0]};
      F3_HU:   result = {{(CPU_WORD-16){1'b0}}, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store controller between the pipeline memory stage and the data memory port.
// Accepts one request at a time, rejects misaligned/illegal requests without touching memory,
// issues one word-aligned transaction with byte enables and returns extended load data.
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_we/funct3/addr/wdata    request fields, latched on acceptance
//   resp_valid/rdata/err        one-cycle completion pulse with data and error flag
//   mem_req/we/addr/be/wdata    memory request, held until mem_gnt
//   mem_gnt                     memory accepted the request
//   mem_rvalid/mem_rdata        load data return
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned CPU_WORD   = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [CPU_WORD-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [CPU_WORD-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [CPU_WORD-1:0]   mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [CPU_WORD-1:0]   mem_rdata
);

  lsu_state_t state_q, state_d;

  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [CPU_WORD-1:0]   mem_wdata_q;
  logic [CPU_WORD-1:0]   resp_rdata_q;
  logic                  resp_err_q;

  logic                  accept;
  logic                  legal;
  logic [3:0]            be_gen;
  logic [CPU_WORD-1:0]   wdata_gen;
  logic [CPU_WORD-1:0]   load_data;

  assign accept = (state_q == StIdle) && req_valid;
  assign legal  = access_ok(req_we, req_funct3, req_addr[1:0]);

  // Byte enables and lane-replicated store data, computed from the request and registered on
  // acceptance so the memory port never sees a combinational path from req_*.
  always_comb begin
    be_gen    = 4'b1111;
    wdata_gen = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_gen    = 4'b0001 << req_addr[1:0];
          wdata_gen = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_gen    = 4'b0011 << req_addr[1:0];
          wdata_gen = {2{req_wdata[15:0]}};
        end
        default: begin
          be_gen    = 4'b1111;
          wdata_gen = req_wdata;
        end
      endcase
    end
  end

  load_align_extend #(
    .CPU_WORD (CPU_WORD)
  ) u_load_align_extend (
    .raw    (mem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .result (load_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = legal ? StIssue : StResp;
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          state_d = we_q ? StResp : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q         <= req_we;
        funct3_q     <= req_funct3;
        off_q        <= req_addr[1:0];
        resp_rdata_q <= '0;
        resp_err_q   <= ~legal;
        // Rejected requests never reach memory, so leave the port registers untouched.
        if (legal) begin
          mem_we_q    <= req_we;
          mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be_q    <= be_gen;
          mem_wdata_q <= wdata_gen;
        end
      end
      if ((state_q == StWait) && mem_rvalid) begin
        resp_rdata_q <= load_data;
      end
      // Response fields are only meaningful alongside resp_valid; clear them afterwards.
      if (state_q == StResp) begin
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = (state_q == StIssue);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(
    .CPU_WORD   (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),  32'd1);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".mem_req"},    32'(mem_req),    32'd0);
    check({tag, ".resp_rdata"}, resp_rdata,      32'h0);
    check({tag, ".resp_err"},   32'(resp_err),   32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle(tag);
    check({tag, ".mem_we"},    32'(mem_we),    32'd0);
    check({tag, ".mem_addr"},  mem_addr,       32'h0);
    check({tag, ".mem_be"},    32'(mem_be),    32'd0);
    check({tag, ".mem_wdata"}, mem_wdata,      32'h0);
  endtask

  // One request from idle. Memory grants after gnt_dly stalled ISSUE cycles and returns load
  // data rv_dly cycles after entering WAIT. Latency counts cycles from acceptance to resp_valid.
  task automatic xact(input string name, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
                      input int gnt_dly, input int rv_dly, input logic [31:0] e_addr,
                      input logic [3:0] e_be, input logic [31:0] e_wdata,
                      input logic [31:0] e_rdata, input logic e_err, input int e_lat);
    int  reqc    = 0;
    int  waitc   = 0;
    bit  granted = 1'b0;
    bit  done    = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      check({name, ".req_ready_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) begin
        check({name, ".rdata"},   resp_rdata,    e_rdata);
        check({name, ".err"},     32'(resp_err), 32'(e_err));
        check({name, ".latency"}, 32'(cyc),      32'(e_lat));
        done = 1'b1;
      end else if (mem_req) begin
        check({name, ".mem_addr"}, mem_addr,     e_addr);
        check({name, ".mem_be"},   32'(mem_be),  32'(e_be));
        check({name, ".mem_we"},   32'(mem_we),  32'(we));
        if (we) check({name, ".mem_wdata"}, mem_wdata, e_wdata);
        // Stray rvalid during ISSUE must not be captured.
        if (!we) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'h5A5A_5A5A;
        end
        if (reqc == gnt_dly) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        reqc++;
      end else if (granted && !we) begin
        if (waitc == rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word;
        end
        waitc++;
      end
      @(negedge clk);
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check({name, ".resp_seen"}, 32'(done), 32'd1);
    check({name, ".req_cycles"}, 32'(reqc), e_err ? 32'd0 : 32'(gnt_dly + 1));
    check_idle({name, ".after"});
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    //   name    we    f3      addr          wdata         word       g  r  e_addr        be       e_wdata       e_rdata       err lat
    xact("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0, 3);
    xact("lhu",  1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h9234_5678, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_9234, 1'b0, 3);
    xact("lh",   1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h9234_5678, 1, 2, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_9234, 1'b0, 6);
    xact("lbu",  1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1122_8344, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0083, 1'b0, 3);
    xact("lw",   1'b0, 3'b010, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h0000_0108, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 4);
    xact("sb",   1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h0,        3, 0, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0, 5);
    xact("sh",   1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 32'h0,        0, 0, 32'h0000_0300, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 2);
    xact("sw",   1'b1, 3'b010, 32'h0000_0404, 32'h89AB_CDEF, 32'h0,        1, 0, 32'h0000_0404, 4'b1111, 32'h89AB_CDEF, 32'h0,        1'b0, 3);
    xact("lw_mis",  1'b0, 3'b010, 32'h0000_0102, 32'h0,     32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);
    xact("sh_mis",  1'b1, 3'b001, 32'h0000_0301, 32'hFFFF,  32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);
    xact("ld_f3_3", 1'b0, 3'b011, 32'h0000_0100, 32'h0,     32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);
    xact("st_f3_4", 1'b1, 3'b100, 32'h0000_0100, 32'h0,     32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);
    xact("ld_f3_6", 1'b0, 3'b110, 32'h0000_0100, 32'h0,     32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);

    // Reset while waiting for load data; the late rvalid after release must be dropped.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst.mem_req_issue", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst.in_wait", 32'(mem_req | req_ready | resp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst.async");
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_reset_outputs("rst.late_rvalid");
      @(negedge clk);
    end

    // Back-to-back stores with req_valid held high.
    begin
      int r1 = -1;
      int r2 = -1;
      int nresp = 0;
      int nreq = 0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0400;
      req_wdata  = 32'hCAFE_F00D;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(negedge clk);
        mem_gnt = 1'b0;
        if (resp_valid) check("b2b.no_overlap", 32'(req_ready), 32'd0);
        if (mem_req) begin
          mem_gnt = 1'b1;
          nreq++;
          if (nresp == 1) begin
            check("b2b.addr2",  mem_addr,    32'h0000_0500);
            check("b2b.be2",    32'(mem_be), 32'(4'b0100));
            check("b2b.wdata2", mem_wdata,   32'h7777_7777);
          end else begin
            check("b2b.wdata1", mem_wdata,   32'hCAFE_F00D);
          end
        end
        if (resp_valid) begin
          nresp++;
          if (nresp == 1) begin
            r1         = cyc;
            req_funct3 = 3'b000;
            req_addr   = 32'h0000_0502;
            req_wdata  = 32'h0000_0077;
          end else if (nresp == 2) begin
            r2        = cyc;
            req_valid = 1'b0;
          end
        end
      end
      mem_gnt = 1'b0;
      check("b2b.resp_count", 32'(nresp), 32'd2);
      check("b2b.req_count",  32'(nreq),  32'd2);
      check("b2b.first_resp", 32'(r1),    32'd2);
      check("b2b.second_resp", 32'(r2),   32'd5);
      check_idle("b2b.after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
